midi_uart_rx: RTL and testbench
===============================

Name: midi_uart_rx

Overview:
- Serial MIDI receiver, 8N1, 31250 baud; the inbound counterpart to the AY port-A bit-banged MIDI output of the sound subsystem.
- Samples a raw MIDI IN line, deframes bytes and buffers them in a small FIFO.
- Presents the FIFO head and status flags to a CPU-visible port decoder (ZX-Uno register space).

Parameters:
CLKDIV, 896, clk cycles per bit (28 MHz / 31250); must be even and >= 8
FIFO_AW, 2, log2 of FIFO depth (default depth 4)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset; clock clk
midi_in  in  1  asynchronous serial line, idle high
rd  in  1  one-cycle pop strobe from port decoder
dout  out  8  FIFO head byte (first-word fall-through)
data_valid  out  1  FIFO not empty
fifo_count  out  FIFO_AW+1  number of bytes held
framing_err  out  1  sticky: stop bit sampled low
overrun  out  1  sticky: byte received while FIFO full
clr_err  in  1  one-cycle strobe, clears framing_err and overrun
busy  out  1  deframer not in IDLE

Behaviour:
- Reset values (reset_n low at a clk edge): dout=0, data_valid=0, fifo_count=0, framing_err=0, overrun=0, busy=0; FSM in IDLE; FIFO pointers 0; synchroniser flops preset to 1.
- Reset mid-frame aborts the frame; no partial byte is stored.
- Input path: 2-flop synchroniser; the FSM uses the second flop ("rxs").
- Bit counter: counts down; "tick" when it reaches 0. Each tick reloads the counter to CLKDIV-1.
- FSM states:
  - IDLE: when rxs==0, load counter with CLKDIV/2-1, go to START.
  - START: on tick, if rxs==1 (glitch), return to IDLE with no flag. Otherwise clear the bit index and go to DATA.
  - DATA: on each tick, shift rxs into bit 7 of the shift register (LSB first). After the 8th sample, go to STOP.
  - STOP: on tick, if rxs==1, push the byte and go to IDLE. If rxs==0, set framing_err, discard the byte and go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE. Covers MIDI break / line low.
- Sample points, with edge E = the cycle rxs first reads 0:
  - start check at E+CLKDIV/2
  - data bit n at E+CLKDIV/2+(n+1)*CLKDIV
  - stop bit at E+CLKDIV/2+9*CLKDIV
- Push latency: the byte is visible on dout and fifo_count increments on the cycle after the stop sample.
- busy=1 in every state except IDLE.
- FIFO behaviour:
  - Circular buffer with depth 2^FIFO_AW; pointers wrap modulo depth.
  - fifo_count spans 0..depth.
  - dout = mem[rd_ptr] when data_valid=1; dout holds its last value when empty.
  - rd while empty is ignored; count never underflows.
  - Push while full with no rd in the same cycle: byte dropped, overrun set, FIFO unchanged.
  - Push and rd in the same cycle, FIFO non-empty: both take effect and the count is unchanged. This includes the full case, where no overrun is flagged.
  - Push and rd in the same cycle, FIFO empty: push takes effect, rd is ignored, count becomes 1.
- Error flags:
  - clr_err clears both sticky flags.
  - If a set event and clr_err land in the same cycle, set wins.
  - Flags never block reception.

Test Plan:
- Simulate with CLKDIV=16. Send 0x90 framed as 0,0000 1001(LSB first),1 -> on the cycle after E+152: data_valid=1, dout=0x90, fifo_count=1, no error flags; rd pulse -> fifo_count=0, data_valid=0.
- Glitch test: drive midi_in low for 4 cycles, then high -> FSM back to IDLE; no push, no flags; busy drops after E+8.
- Send 0x3C with the stop bit low, holding the line low for 40 more cycles -> framing_err=1, fifo_count=0, busy=1 until the line returns high. Then send 0x45 -> received correctly with framing_err still 1. Pulse clr_err -> framing_err=0.
- Send 0x01..0x05 back-to-back with no reads -> fifo_count=4, overrun=1 after the 5th stop bit. Read 4 times -> dout sequence 0x01,0x02,0x03,0x04.
- Fill to 4; assert rd on the exact cycle the 5th byte 0x77 pushes -> overrun=0, fifo_count=4, last element read out is 0x77 (pointer wrap verified).
- Assert reset_n low during bit 3 of a frame, then release -> all outputs at reset values, fifo_count=0. Next frame 0xF8 -> received intact.

Source files
------------

// File: rtl/midi_uart_rx.sv
// MIDI IN receiver: 8N1 deframer with a small first-word-fall-through FIFO and
// sticky framing/overrun flags for the CPU port decoder.
//
// state   | meaning
// IDLE    | line idle, waiting for a falling edge on rxs
// START   | half-bit wait, then confirm the start bit is still low
// DATA    | sampling 8 data bits LSB first, one per bit period
// STOP    | sampling the stop bit; push on high, framing error on low
// BREAK   | line held low after a bad stop bit, wait for it to return high
module midi_uart_rx #(
  parameter int CLKDIV  = 896,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               midi_in,
  input  logic               rd,
  output logic [7:0]         dout,
  output logic               data_valid,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               framing_err,
  output logic               overrun,
  input  logic               clr_err,
  output logic               busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(CLKDIV);
  localparam logic [CW-1:0]    CNT_FULL = CW'(CLKDIV - 1);
  localparam logic [CW-1:0]    CNT_HALF = CW'(CLKDIV / 2 - 1);
  localparam logic [FIFO_AW:0] CNT_MAX  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t             state, state_nx;
  logic               sync1, rxs;
  logic [CW-1:0]      cnt;
  logic               tick;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               push, frame_bad;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]         last_head;
  logic               do_rd, do_wr, full;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= midi_in;
      rxs   <= sync1;
    end
  end

  assign tick = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (!rxs) state_nx = S_START;
      S_START: if (tick) state_nx = rxs ? S_IDLE : S_DATA;
      S_DATA:  if (tick && bit_idx == 3'd7) state_nx = S_STOP;
      S_STOP:  if (tick) state_nx = rxs ? S_IDLE : S_BREAK;
      S_BREAK: if (rxs) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    push      = (state == S_STOP) && tick && rxs;
    frame_bad = (state == S_STOP) && tick && !rxs;
  end

  // Counter is only armed from IDLE; every tick thereafter reloads a full bit period.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state == S_IDLE) begin
      if (!rxs) cnt <= CNT_HALF;
    end else if (tick) begin
      cnt <= CNT_FULL;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else if (state == S_START && tick) begin
      bit_idx <= '0;
    end else if (state == S_DATA && tick) begin
      shreg   <= {rxs, shreg[7:1]};
      bit_idx <= bit_idx + 3'd1;
    end
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO with rd still lands.
  assign full  = (fifo_count == CNT_MAX);
  assign do_rd = rd && data_valid;
  assign do_wr = push && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      last_head  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (do_wr && !do_rd)      fifo_count <= fifo_count + (FIFO_AW + 1)'(1);
      else if (do_rd && !do_wr) fifo_count <= fifo_count - (FIFO_AW + 1)'(1);
      if (data_valid) last_head <= mem[rd_ptr];
    end
  end

  assign data_valid = (fifo_count != '0);
  assign dout       = data_valid ? mem[rd_ptr] : last_head;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (frame_bad)    framing_err <= 1'b1;
      else if (clr_err) framing_err <= 1'b0;
      if (push && full && !do_rd) overrun <= 1'b1;
      else if (clr_err)           overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_midi_uart_rx.sv
// Scoreboard bench for midi_uart_rx: a queue-based FIFO model predicts every
// read, a negedge monitor compares whenever the bench pops the DUT.
module tb_midi_uart_rx;
  localparam int CLKDIV = 16;
  localparam int AW     = 2;
  localparam int DEPTH  = 4;
  localparam int FRAME  = 10 * CLKDIV;

  logic          clk = 1'b0;
  logic          reset_n, midi_in, rd, clr_err;
  logic [7:0]    dout;
  logic          data_valid, framing_err, overrun, busy;
  logic [AW:0]   fifo_count;

  midi_uart_rx #(.CLKDIV(CLKDIV), .FIFO_AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .midi_in(midi_in), .rd(rd),
    .dout(dout), .data_valid(data_valid), .fifo_count(fifo_count),
    .framing_err(framing_err), .overrun(overrun), .clr_err(clr_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         valid;
    logic [7:0] data;
  } rd_exp_t;

  rd_exp_t    exp_q[$];
  logic [7:0] model_q[$];
  bit         model_fe, model_ov;
  int         n_cmp = 0;
  int         n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural model of one completed frame arriving at the FIFO.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)                   model_fe = 1'b1;
    else if (model_q.size() == DEPTH) model_ov = 1'b1;
    else                            model_q.push_back(b);
  endtask

  task automatic model_read();
    rd_exp_t e;
    e.valid = (model_q.size() != 0);
    e.data  = e.valid ? model_q.pop_front() : 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, fifo_count, model_q.size());
    check({tag, "_valid"}, data_valid, model_q.size() != 0);
    check({tag, "_framing_err"}, framing_err, model_fe);
    check({tag, "_overrun"}, overrun, model_ov);
  endtask

  // Drive one frame bit by bit; rd_at >= 0 pops on that cycle of the frame.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold,
                            input int rd_at, input int gap);
    logic [9:0] bits;
    int total;
    bits  = {stop_ok, b, 1'b0};
    total = FRAME + (stop_ok ? 0 : hold);
    for (int k = 0; k < total; k++) begin
      midi_in = (k < FRAME) ? bits[k / CLKDIV] : 1'b0;
      if (k == rd_at) begin
        rd = 1'b1;
        model_read();
      end else if (k == rd_at + 1) begin
        rd = 1'b0;
      end
      if (!stop_ok && k == FRAME + 10) check("busy_in_break", busy, 1);
      step();
    end
    midi_in = 1'b1;
    model_frame(b, stop_ok);
    repeat (gap) step();
  endtask

  task automatic do_read();
    rd = 1'b1;
    model_read();
    step();
    rd = 1'b0;
  endtask

  task automatic do_clr();
    clr_err  = 1'b1;
    model_fe = 1'b0;
    model_ov = 1'b0;
    step();
    clr_err = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rd      = 1'b0;
    clr_err = 1'b0;
    midi_in = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    model_q.delete();
    model_fe = 1'b0;
    model_ov = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    rd_exp_t e;
    if (reset_n && rd) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rd_unexpected: got pop with no prediction, expected none (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("rd_valid", data_valid, e.valid);
        if (e.valid) check("rd_dout", dout, e.data);
      end
    end
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] bits;
    reset_n = 1'b0;
    midi_in = 1'b1;
    rd      = 1'b0;
    clr_err = 1'b0;
    repeat (3) step();
    check("rst_dout", dout, 8'h00);
    check("rst_busy", busy, 0);
    check_state("rst");
    reset_n = 1'b1;
    step();

    // Single byte 0x90 then pop
    send_frame(8'h90, 1'b1, 0, -1, 4);
    check("b90_dout", dout, 8'h90);
    check_state("b90");
    do_read();
    check_state("b90_pop");
    check("b90_hold_dout", dout, 8'h90);

    // Start-bit glitch
    midi_in = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k == 4) midi_in = 1'b1;
      if (k == 6) check("glitch_busy_hi", busy, 1);
      if (k == 14) check("glitch_busy_lo", busy, 0);
      step();
    end
    check_state("glitch");

    // Bad stop bit followed by a long low line, then a good byte
    send_frame(8'h3C, 1'b0, 40, -1, 4);
    check("brk_busy_lo", busy, 0);
    check_state("brk");
    send_frame(8'h45, 1'b1, 0, -1, 4);
    check_state("after_brk");
    do_read();
    do_clr();
    check_state("clr1");

    // Back-to-back bytes into a full FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, -1, 0);
    repeat (4) step();
    check_state("ovr");
    repeat (4) do_read();
    check_state("ovr_drained");
    do_clr();

    // Push and pop coincide on a full FIFO
    for (int i = 0; i < 4; i++) send_frame(8'hA1 + 8'(i), 1'b1, 0, -1, 0);
    send_frame(8'h77, 1'b1, 0, 9 * CLKDIV + CLKDIV / 2 + 2, 4);
    check_state("wrap_full");
    repeat (4) do_read();
    check_state("wrap_drained");

    // Reset during data bit 3
    bits = {1'b1, 8'h5A, 1'b0};
    for (int k = 0; k < 4 * CLKDIV + 6; k++) begin
      midi_in = bits[k / CLKDIV];
      step();
    end
    do_reset();
    check("mid_rst_dout", dout, 8'h00);
    check("mid_rst_busy", busy, 0);
    check_state("mid_rst");
    send_frame(8'hF8, 1'b1, 0, -1, 4);
    check_state("f8");
    do_read();

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0, 20, -1,
                 $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) do_read();
      if ($urandom_range(0, 5) == 0) do_clr();
      check_state("rnd");
    end
    repeat (DEPTH + 1) do_read();
    check_state("final");

    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
